// File: rtl/piso_stream_if.sv
// Word-side handshake and serial-side outputs of piso_stream, bundled as one port.
// The slave modport is the serializer; the master modport is the word producer / link consumer.
interface piso_stream_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             out;
  logic             out_valid;
  logic             word_done;

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out,
    output out_valid,
    output word_done
  );

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out,
    input  out_valid,
    input  word_done
  );
endinterface

// File: rtl/piso_stream.sv
// Parallel-in/serial-out serializer with a one-word holding register so that
// back-to-back words leave the serial link with no idle cycle between them.
module piso_stream #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic           clk,
  input logic           rst,
  piso_stream_if.slave  bus
);

  // Handshake: a word transfers on a rising edge where in_valid and in_ready are
  // both high; in_ready depends only on the holding register, never on in_valid.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             hold_valid_q, hold_valid_d;
  logic             ready_q, ready_d;
  logic             out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             word_done_q, word_done_d;

  logic             accept;
  logic             last;
  logic             load_slot;
  logic             load_en;
  logic [WIDTH-1:0] load_word;

  always_comb begin
    accept       = bus.in_valid && ready_q;
    last         = out_valid_q && (cnt_q == CNT_LAST);
    load_slot    = !out_valid_q || last;

    sr_d         = sr_q;
    hold_d       = hold_q;
    cnt_d        = cnt_q;
    hold_valid_d = hold_valid_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    load_en      = 1'b0;
    load_word    = hold_q;

    // A held word always wins the load slot; in_ready is low whenever it exists.
    if (load_slot && hold_valid_q) begin
      load_en      = 1'b1;
      load_word    = hold_q;
      hold_valid_d = 1'b0;
    end else if (load_slot && accept) begin
      load_en      = 1'b1;
      load_word    = bus.in_data;
    end else if (accept) begin
      hold_d       = bus.in_data;
      hold_valid_d = 1'b1;
    end

    if (load_en) begin
      out_d       = MSB_FIRST ? load_word[WIDTH-1] : load_word[0];
      sr_d        = MSB_FIRST ? (load_word << 1) : (load_word >> 1);
      cnt_d       = '0;
      out_valid_d = 1'b1;
    end else if (out_valid_q && !last) begin
      out_d       = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
      sr_d        = MSB_FIRST ? (sr_q << 1) : (sr_q >> 1);
      cnt_d       = cnt_q + CW'(1);
    end else if (last) begin
      out_valid_d = 1'b0;
      out_d       = 1'b0;
    end

    word_done_d = out_valid_d && (cnt_d == CNT_LAST);
    ready_d     = !hold_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q         <= '0;
      hold_q       <= '0;
      cnt_q        <= '0;
      hold_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      out_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      word_done_q  <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      hold_valid_q <= hold_valid_d;
      ready_q      <= ready_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      word_done_q  <= word_done_d;
    end
  end

  assign bus.in_ready  = ready_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.word_done = word_done_q;

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: directed 16-bit vectors in both bit orders, back-to-back,
// queued producer and mid-word reset, then a randomized 4-bit stream against a model.
module tb_piso_stream;

  logic clk;
  logic rst;

  piso_stream_if #(.WIDTH(16)) if_a ();
  piso_stream_if #(.WIDTH(16)) if_b ();
  piso_stream_if #(.WIDTH(4))  if_c ();

  piso_stream #(.WIDTH(16), .MSB_FIRST(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  piso_stream #(.WIDTH(16), .MSB_FIRST(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  piso_stream #(.WIDTH(4),  .MSB_FIRST(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (word/bit-count level) ----------------
  // rem = bits of the current word still to be shown, counting the one on out now.
  typedef struct {
    int          rem;
    logic [15:0] cur;
    logic        held_v;
    logic [15:0] held;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mdl_step(input mdl_t s, input logic acc, input logic [15:0] d, input int w);
    mdl_t n = s;
    if (s.rem <= 1) begin
      if (s.held_v) begin
        n.cur = s.held; n.rem = w; n.held_v = 1'b0;
      end else if (acc) begin
        n.cur = d; n.rem = w;
      end else begin
        n.rem = 0;
      end
    end else begin
      n.rem = s.rem - 1;
      if (acc) begin
        n.held = d; n.held_v = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic mdl_out(input mdl_t s, input int w);
    return (s.rem > 0) ? s.cur[w - s.rem] : 1'b0;
  endfunction

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] asm_word;
  int          bitpos;
  int          acc_cnt;
  int          done_cnt;

  task automatic mdl_reset();
    m        = '{rem: 0, cur: 16'h0, held_v: 1'b0, held: 16'h0};
    exp_q.delete();
    asm_word = '0;
    bitpos   = 0;
    acc_cnt  = 0;
    done_cnt = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample(input int sel, output logic o, output logic ov, output logic wd, output logic rdy);
    case (sel)
      0:       begin o = if_a.out; ov = if_a.out_valid; wd = if_a.word_done; rdy = if_a.in_ready; end
      1:       begin o = if_b.out; ov = if_b.out_valid; wd = if_b.word_done; rdy = if_b.in_ready; end
      default: begin o = if_c.out; ov = if_c.out_valid; wd = if_c.word_done; rdy = if_c.in_ready; end
    endcase
  endtask

  task automatic drive(input int sel, input logic v, input logic [15:0] d);
    case (sel)
      0:       begin if_a.in_valid = v; if_a.in_data = d; end
      1:       begin if_b.in_valid = v; if_b.in_data = d; end
      default: begin if_c.in_valid = v; if_c.in_data = d[3:0]; end
    endcase
  endtask

  // One cycle: compare DUT against the model, feed the scoreboard, then drive the next inputs.
  task automatic model_cycle(input int sel, input int w, input logic v, input logic [15:0] d, output logic acc);
    logic o, ov, wd, rdy;
    logic [15:0] mask;
    mask = 16'hFFFF >> (16 - w);
    @(negedge clk);
    sample(sel, o, ov, wd, rdy);
    check($sformatf("model sel%0d {out,valid,done,ready}", sel), {o, ov, wd, rdy},
          {mdl_out(m, w), m.rem > 0, m.rem == 1, !m.held_v});
    if (ov) begin
      if (bitpos < 16) asm_word[bitpos] = o;
      bitpos++;
      if (wd) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_word got %h expected none (no word queued)", asm_word);
        end else begin
          check("sb_word", asm_word & mask, exp_q.pop_front());
        end
        asm_word = '0;
        bitpos   = 0;
      end
    end
    drive(sel, v, d);
    acc = v && !m.held_v;
    if (acc) begin
      exp_q.push_back(d & mask);
      acc_cnt++;
    end
    m = mdl_step(m, acc, d & mask, w);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic vin;
    logic ea;
    logic eb;
    logic ev;
    logic ed;
    logic er;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic o_a, ov_a, wd_a, rdy_a, o_b, ov_b, wd_b, rdy_b;
    logic [15:0] lsb_seq, msb_seq, w1234;
    logic [15:0] words[3];
    logic acc, v;
    logic [15:0] cur_d;
    int idx, cyc;

    rst = 1'b1;
    drive(0, 1'b0, 16'h0);
    drive(1, 1'b0, 16'h0);
    drive(2, 1'b0, 16'h0);

    // ---- reset state, and in_valid ignored under reset ----
    repeat (3) @(negedge clk);
    sample(0, o_a, ov_a, wd_a, rdy_a);
    check("reset a", {o_a, ov_a, wd_a, rdy_a}, 4'b0001);
    sample(2, o_b, ov_b, wd_b, rdy_b);
    check("reset c", {o_b, ov_b, wd_b, rdy_b}, 4'b0001);
    drive(0, 1'b1, 16'hFFFF);
    @(negedge clk);
    sample(0, o_a, ov_a, wd_a, rdy_a);
    check("valid under reset", {o_a, ov_a, wd_a, rdy_a}, 4'b0001);
    drive(0, 1'b0, 16'h0);
    rst = 1'b0;

    // ---- single word 0xA5C3, both bit orders ----
    lsb_seq = 16'b1100001110100101;
    msb_seq = 16'b1010010111000011;
    for (int i = 0; i < 18; i++) begin
      tbl[i].vin = (i == 0);
      tbl[i].er  = 1'b1;
      if (i >= 1 && i <= 16) begin
        tbl[i].ea = lsb_seq[16-i];
        tbl[i].eb = msb_seq[16-i];
        tbl[i].ev = 1'b1;
        tbl[i].ed = (i == 16);
      end else begin
        tbl[i].ea = 1'b0;
        tbl[i].eb = 1'b0;
        tbl[i].ev = 1'b0;
        tbl[i].ed = 1'b0;
      end
    end
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      sample(0, o_a, ov_a, wd_a, rdy_a);
      sample(1, o_b, ov_b, wd_b, rdy_b);
      check($sformatf("a5c3 row%0d", i), {o_a, o_b, ov_a, ov_b, wd_a, wd_b, rdy_a, rdy_b},
            {tbl[i].ea, tbl[i].eb, tbl[i].ev, tbl[i].ev, tbl[i].ed, tbl[i].ed, tbl[i].er, tbl[i].er});
      drive(0, tbl[i].vin, 16'hA5C3);
      drive(1, tbl[i].vin, 16'hA5C3);
    end

    // ---- back-to-back 0xFFFF then 0x0000 ----
    for (int c = 0; c < 34; c++) begin
      @(negedge clk);
      sample(0, o_a, ov_a, wd_a, rdy_a);
      check($sformatf("b2b cyc%0d", c), {o_a, ov_a, wd_a, rdy_a},
            {(c >= 1 && c <= 16), (c >= 1 && c <= 32), (c == 16 || c == 32), !(c >= 2 && c <= 16)});
      if (c == 0)      drive(0, 1'b1, 16'hFFFF);
      else if (c == 1) drive(0, 1'b1, 16'h0000);
      else             drive(0, 1'b0, 16'h0000);
    end

    // ---- producer keeps in_valid high with 3 words queued ----
    mdl_reset();
    words[0] = 16'h8001;
    words[1] = 16'h3C5A;
    words[2] = 16'hF00D;
    idx = 0;
    for (int c = 0; c < 60; c++) begin
      v = (idx < 3);
      model_cycle(0, 16, v, (idx < 3) ? words[idx] : 16'h0, acc);
      if (acc) idx++;
    end
    check("queued accepted", idx, 3);
    check("queued word_done count", done_cnt, 3);
    check("queued sb empty", exp_q.size(), 0);

    // ---- reset mid-word with a second word held ----
    w1234 = 16'h1234;
    @(negedge clk);
    drive(0, 1'b1, 16'h1234);
    @(negedge clk);
    drive(0, 1'b1, 16'hBEEF);
    @(negedge clk);
    drive(0, 1'b0, 16'h0);
    sample(0, o_a, ov_a, wd_a, rdy_a);
    check("held ready low", rdy_a, 1'b0);
    repeat (6) @(negedge clk);
    sample(0, o_a, ov_a, wd_a, rdy_a);
    check("bit7 of 1234", {o_a, ov_a, wd_a, rdy_a}, {w1234[7], 1'b1, 1'b0, 1'b0});
    #2 rst = 1'b1;
    #1;
    sample(0, o_a, ov_a, wd_a, rdy_a);
    check("async reset mid-word", {o_a, ov_a, wd_a, rdy_a}, 4'b0001);
    drive(0, 1'b1, 16'hFFFF);
    @(negedge clk);
    sample(0, o_a, ov_a, wd_a, rdy_a);
    check("reset held", {o_a, ov_a, wd_a, rdy_a}, 4'b0001);
    drive(0, 1'b0, 16'h0);
    rst = 1'b0;
    mdl_reset();
    for (int c = 0; c < 20; c++) model_cycle(0, 16, (c == 0), 16'h0001, acc);
    check("post-reset word_done count", done_cnt, 1);
    check("post-reset sb empty", exp_q.size(), 0);

    // ---- WIDTH=4 randomized stream, 1000 words ----
    mdl_reset();
    cur_d = 16'($urandom_range(0, 15));
    cyc = 0;
    while (acc_cnt < 1000 && cyc < 20000) begin
      v = ($urandom_range(0, 3) != 0);
      model_cycle(2, 4, v, cur_d, acc);
      if (acc) cur_d = 16'($urandom_range(0, 15));
      cyc++;
    end
    for (int c = 0; c < 12; c++) model_cycle(2, 4, 1'b0, 16'h0, acc);
    check("random accepted words", acc_cnt, 1000);
    check("random word_done count", done_cnt, acc_cnt);
    check("random sb empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_stream.md
# piso_stream

Parametrised parallel-in/serial-out serializer with a valid/ready input handshake and a one-word holding register. Back-to-back words leave with no idle cycle between them. It sits between a word-producing datapath stage and a 1-bit serial link. It generalises the fixed 16-bit LSB-first serializer with configurable width, selectable bit order, flow control and a continuous-stream capability.

## Interface

- WIDTH, 16, bits per word; legal range is 2 or more.
- MSB_FIRST, 0, bit order: 0 sends bit 0 first, 1 sends bit WIDTH-1 first.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_data  input  WIDTH  parallel word.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can accept a word; equals NOT hold_valid, driven directly from a register.
- out  output  1  serial bit, registered.
- out_valid  output  1  out carries a valid data bit this cycle.
- word_done  output  1  high only in the cycle that presents the final bit of a word.

## Operation

- Internal state:
  - shift register sr[WIDTH-1:0]
  - bit counter cnt, $clog2(WIDTH) bits
  - holding register hold[WIDTH-1:0] with flag hold_valid.
- Definitions:
  - accept = in_valid AND in_ready, sampled at the rising edge.
  - last = out_valid AND cnt == WIDTH-1.
  - load_slot = NOT out_valid OR last.
- Priority at each edge, first match wins:
  1. load_slot AND hold_valid: load the shifter from hold. If accept is also true, in_data goes into hold and hold_valid stays 1; otherwise hold_valid clears. Since in_ready = NOT hold_valid, accept is 0 in this case, so hold_valid always clears.
  2. load_slot AND accept: load the shifter directly from in_data.
  3. accept, with no load slot: capture in_data in hold and set hold_valid.
  4. out_valid AND NOT last: shift one position and increment cnt.
  5. last with nothing to load: clear out_valid, out and word_done to 0.
- Loading the shifter does all of the following on the same edge:
  - out takes the first bit: in[0] when MSB_FIRST=0, in[WIDTH-1] when MSB_FIRST=1.
  - sr takes the remaining bits.
  - cnt goes to 0 and out_valid goes to 1.
- Shift direction: right when MSB_FIRST=0, left when MSB_FIRST=1. Vacated positions fill with 0.
- word_done is registered. It is set on the edge where the next cnt equals WIDTH-1 and out_valid stays 1, and cleared on every other edge.
- hold and sr contents are don't-care while their valid flags are low, but they reset to 0.
- Holding off in_valid never corrupts a word in flight. There is no abort; only rst cancels a word.

## Timing

- Reset values: out=0, out_valid=0, word_done=0, hold_valid=0 (so in_ready=1), cnt=0, sr=0, hold=0.
- Reset is asynchronous. Asserting rst mid-word clears everything immediately; the partial word and any held word are discarded. in_valid is ignored while rst is high.
- Latency: a word accepted at edge E from idle presents bit 0 in cycle E+1 and the final bit in cycle E+WIDTH, with word_done high in that final cycle.
- Throughput: one word per WIDTH cycles with no gaps, provided the next word is held or presented by the last-bit edge.
- Back-to-back behaviour:
  - Word 2 accepted while word 1 is shifting goes into hold, and in_ready drops the next cycle.
  - The edge that ends word 1 loads word 2. hold_valid clears and in_ready rises in the following cycle.
- in_valid in the same cycle as the last bit with hold empty loads directly (rule 2), so there is no gap.
- While hold is full, in_ready stays 0. The producer keeps in_data and in_valid stable, because no data is dropped.

## Test plan

- WIDTH=16, MSB_FIRST=0, single word 0xA5C3 from idle -> out sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. out_valid is high for exactly 16 cycles, and word_done is high only in the 16th cycle.
- MSB_FIRST=1, word 0xA5C3 -> out sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1. word_done is high on the final 1.
- Back-to-back 0xFFFF then 0x0000, with the second word offered the cycle after the first is accepted -> 32 consecutive out_valid cycles. word_done pulses at cycles 16 and 32. in_ready is 0 from cycle 2 through cycle 16.
- Producer holds in_valid high with 3 words queued -> in_ready deasserts while hold is full. All 3 words are emitted in order, gapless, with no word lost or duplicated.
- Reset mid-word: assert rst at bit 7 of 0x1234 while a second word is held -> out, out_valid and word_done go to 0 immediately and in_ready goes to 1. After release, a new 0x0001 serializes correctly from bit 0.
- WIDTH=4, random in_valid stream checked against a scoreboard over 1000 words -> serial output matches the accepted words exactly. word_done count equals the accepted word count.
